mix_columns_iter: RTL and testbench
===================================

# mix_columns_iter

Iterative, parametrised AES MixColumns / InvMixColumns engine. It accepts a full state of NCOL 32-bit columns over a valid/ready handshake and transforms CPC columns per cycle using shared GF(2^8) constant-multiply datapaths. It returns the result on a second valid/ready handshake. It sits between the ShiftRows/InvShiftRows and AddRoundKey stages of a multi-cycle round datapath, and serves both encrypt and decrypt through a per-transaction mode bit.

## Interface
- NCOL, 4, number of 32-bit columns per state; must be ≥1.
- CPC, 1, columns transformed per cycle; must divide NCOL, otherwise elaboration fails.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  engine can accept a state.
- in_inv  in  1  mode: 0 = MixColumns, 1 = InvMixColumns; sampled on the input handshake.
- in_state  in  32*NCOL  column c occupies bits [32c+31:32c]; within a column, bits [31:24] are row 0 and bits [7:0] are row 3.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_state  out  32*NCOL  result state, same layout as in_state.
- busy  out  1  high in RUN or DONE.

## Operation
- Arithmetic is GF(2^8) with reduction polynomial 0x11B. xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0). All products are XOR-combinations of xtime chains, with no carries. All results are 8 bits.
- Forward matrix rows (applied to row0..row3 of a column): {02,03,01,01}, {01,02,03,01}, {01,01,02,03}, {03,01,01,02}.
- Inverse matrix rows: {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
- The mode register selects the matrix per transaction. Both matrices share the CPC column units.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, load the working register from in_state, latch in_inv, clear the column counter, and go to RUN.
  - RUN: each cycle, columns [cnt*CPC .. cnt*CPC+CPC-1] of the working register are replaced in place with their transformed values, then cnt increments. When cnt reaches NCOL/CPC-1 and that group is written, go to DONE. Column 0 is processed first.
  - DONE: out_valid=1 and out_state is held stable. On out_ready, go to IDLE. in_valid is ignored in RUN and DONE.
- The counter width is clog2(NCOL/CPC), with a minimum of 1 bit. For NCOL/CPC=1, the counter never advances and RUN lasts exactly one cycle.
- out_state is the working register at all times. It is only meaningful while out_valid=1.
- Reset (asserted at any time, including mid-RUN or mid-DONE) aborts the transaction immediately. The partial result is discarded.
- Reset values: state=IDLE, working register=0, mode=0, cnt=0. Outputs: out_valid=0, out_state=0, busy=0, in_ready=0 while rst_n=0, and 1 from the first cycle after release.

## Timing
- Latency: with the accept edge as edge 0, out_valid rises after edge NCOL/CPC. This is 4 cycles for (4,1), 2 cycles for (4,2) and 1 cycle for (4,4).
- Throughput: in_ready returns the cycle after the output handshake edge. Sustained rate is one state per NCOL/CPC+2 cycles.
- in_ready and out_valid are decoded directly from the state register. No combinational path runs from in_valid to in_ready or from out_ready to out_valid.
- Under out_ready=0, DONE persists indefinitely with out_state bit-stable.
- The only combinational path per cycle is CPC column units plus a 2:1 matrix select. No path runs from in_state to out_state.

## Test plan
- Forward, NCOL=4/CPC=1:
  - Stimulus: in_state = {2d26314c, d4d4d4d5, f20a225c, db135345} (col3..col0), in_inv=0.
  - Required: out_state = {4d7ebdf8, d5d5d7d6, 9fdc589d, 8e4da1bc`}, out_valid high exactly 4 cycles after accept, busy high throughout.
- Inverse:
  - Stimulus: the forward output above with in_inv=1.
  - Required: the original state is returned. Also {c6c6c6c6, 01010101, ...} maps to itself in both modes.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles with in_valid pulsing.
  - Required: out_state stable, in_ready=0, no second accept. Raising out_ready gives one handshake, then in_ready=1 on the next cycle.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 two cycles after accept.
  - Required: out_valid, busy and out_state are 0 immediately. No out_valid follows. A fresh transaction after release yields correct data.
- Parameter sweep:
  - Stimulus: (NCOL,CPC) = (4,2), (4,4), (8,2), running the vector from the forward test, replicated for NCOL=8.
  - Required: identical data, with latency 2, 1 and 4 respectively.
- Back-to-back random:
  - Stimulus: 1000 random states with in_valid held high and out_ready random.
  - Required: output matches the golden model. Forward followed by inverse yields identity. Accept spacing is never below NCOL/CPC+2 cycles.

Source files
------------

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative AES MixColumns/InvMixColumns engine, CPC columns per cycle
module mix_columns_iter #(
    parameter int NCOL = 4,
    parameter int CPC  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [32*NCOL-1:0]   in_state,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*NCOL-1:0]   out_state,
    output logic                 busy
);

    localparam int NGRP = NCOL / CPC;
    localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NGRP - 1);

    generate
        if (NCOL < 1 || CPC < 1 || (NCOL % CPC) != 0) begin : g_param_check
            $error("mix_columns_iter: NCOL must be >= 1 and divisible by CPC");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [32*NCOL-1:0] work;
    logic               mode;
    logic [CW-1:0]      cnt;
    logic [31:0]        col_res [CPC];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column unit: both matrices are built from the same xtime chain, mode picks the result.
    function automatic logic [31:0] mix(input logic [31:0] c, input logic inv);
        logic [7:0]  a  [4];
        logic [7:0]  m2 [4];
        logic [7:0]  m4 [4];
        logic [7:0]  m8 [4];
        logic [31:0] f;
        logic [31:0] v;
        f = '0;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            m2[i] = xt(a[i]);
            m4[i] = xt(m2[i]);
            m8[i] = xt(m4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            f[31-8*i -: 8] = m2[i] ^ m2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
            v[31-8*i -: 8] = (m8[i] ^ m4[i] ^ m2[i])
                           ^ (m8[(i+1)%4] ^ m2[(i+1)%4] ^ a[(i+1)%4])
                           ^ (m8[(i+2)%4] ^ m4[(i+2)%4] ^ a[(i+2)%4])
                           ^ (m8[(i+3)%4] ^ a[(i+3)%4]);
        end
        return inv ? v : f;
    endfunction

    always_comb begin
        for (int g = 0; g < CPC; g++) begin
            col_res[g] = mix(work[(int'(cnt)*CPC + g)*32 +: 32], mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_n = RUN;
            RUN:     if (cnt == LAST) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Column groups are rewritten in place, so the working register doubles as the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            mode <= 1'b0;
            cnt  <= '0;
        end else if (state == IDLE && in_valid) begin
            work <= in_state;
            mode <= in_inv;
            cnt  <= '0;
        end else if (state == RUN) begin
            for (int g = 0; g < CPC; g++) begin
                work[(int'(cnt)*CPC + g)*32 +: 32] <= col_res[g];
            end
            if (cnt != LAST) cnt <= cnt + CW'(1);
        end
    end

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_state = work;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb/tb_mix_columns_iter.sv - scoreboard bench for mix_columns_iter
module tb_mix_columns_iter;

    localparam logic [127:0] V_IN  = 128'h2d26314c_d4d4d4d5_f20a225c_db135345;
    localparam logic [127:0] V_OUT = 128'h4d7ebdf8_d5d5d7d6_9fdc589d_8e4da1bc;
    localparam logic [127:0] V_FIX = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_inv, out_ready;
    logic [127:0] in_state;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_state;

    logic         sv, sinv, sro;
    logic [127:0] s4;
    logic [255:0] s8;
    logic         rdy2, rdy4, rdy8, ov2, ov4, ov8, bz2, bz4, bz8;
    logic [127:0] os2, os4;
    logic [255:0] os8;

    int tests = 0;
    int fails = 0;
    logic [127:0] exp_q [$];

    mix_columns_iter #(.NCOL(4), .CPC(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy));

    mix_columns_iter #(.NCOL(4), .CPC(2)) u_sw2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(rdy2), .in_inv(sinv),
        .in_state(s4), .out_valid(ov2), .out_ready(sro), .out_state(os2), .busy(bz2));

    mix_columns_iter #(.NCOL(4), .CPC(4)) u_sw4 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(rdy4), .in_inv(sinv),
        .in_state(s4), .out_valid(ov4), .out_ready(sro), .out_state(os4), .busy(bz4));

    mix_columns_iter #(.NCOL(8), .CPC(2)) u_sw8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(rdy8), .in_inv(sinv),
        .in_state(s8), .out_valid(ov8), .out_ready(sro), .out_state(os8), .busy(bz8));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [255:0] model(input logic [255:0] s, input logic inv, input int ncol);
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [255:0] r;
        if (inv) begin
            base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        end else begin
            base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < ncol; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(s[32*c+31-8*k -: 8], base[(k - row + 4) % 4]);
                r[32*c+31-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic run_one(input logic [127:0] s, input logic inv, input string name,
                           output logic [127:0] res);
        logic [255:0] m;
        logic [127:0] e;
        int t, lat, busy_bad;
        res = '0;
        @(negedge clk);
        in_state = s; in_inv = inv; in_valid = 1'b1; out_ready = 1'b1;
        m = model({128'h0, s}, inv, 4);
        exp_q.push_back(m[127:0]);
        t = 0;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL %s_accept: in_ready=%b required 1 within 20 cycles", name, in_ready);
            in_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; busy_bad = 0;
        do begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 50);
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL %s_latency: got %0d required 4", name, lat);
        end
        tests++;
        if (busy_bad !== 0) begin
            fails++;
            $display("FAIL %s_busy: %0d cycles low required 0", name, busy_bad);
        end
        e = exp_q.pop_front();
        res = out_state;
        tests++;
        if (out_state !== e) begin
            fails++;
            $display("FAIL %s_data: got %h required %h", name, out_state, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_state = '0; out_ready = 1'b0;
        sv = 1'b0; sinv = 1'b0; sro = 1'b1; s4 = '0; s8 = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
        tests++; if (out_state !== '0)   begin fails++; $display("FAIL rst_out_state: got %h required 0", out_state); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_forward();
        logic [127:0] r;
        run_one(V_IN, 1'b0, "fwd", r);
        tests++;
        if (r !== V_OUT) begin fails++; $display("FAIL fwd_vector: got %h required %h", r, V_OUT); end
    endtask

    task automatic test_inverse();
        logic [127:0] r, x, y;
        run_one(V_OUT, 1'b1, "inv", r);
        tests++;
        if (r !== V_IN) begin fails++; $display("FAIL inv_vector: got %h required %h", r, V_IN); end
        run_one(V_FIX, 1'b0, "fix_fwd", r);
        tests++;
        if (r !== V_FIX) begin fails++; $display("FAIL fix_fwd_vector: got %h required %h", r, V_FIX); end
        run_one(V_FIX, 1'b1, "fix_inv", r);
        tests++;
        if (r !== V_FIX) begin fails++; $display("FAIL fix_inv_vector: got %h required %h", r, V_FIX); end
        for (int i = 0; i < 4; i++) begin
            x = rand128();
            run_one(x, 1'b0, "chain_fwd", y);
            run_one(y, 1'b1, "chain_inv", r);
            tests++;
            if (r !== x) begin fails++; $display("FAIL chain_identity: got %h required %h", r, x); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] e;
        int t, bad;
        @(negedge clk);
        out_ready = 1'b0; in_state = V_IN; in_inv = 1'b0; in_valid = 1'b1;
        exp_q.push_back(V_OUT);
        @(posedge clk); #1;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            in_valid = ~in_valid; in_state = rand128();
            @(posedge clk); #1;
            t++;
        end
        e = exp_q.pop_front();
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_done: out_valid=%b required 1", out_valid); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid; in_state = rand128(); in_inv = 1'b1;
            @(posedge clk); #1;
            if (out_state !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d out_state=%h in_ready=%b out_valid=%b required %h,0,1",
                         i, out_state, in_ready, out_valid, e);
            end
        end
        tests++;
        if (bad !== 0) fails++;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b required 0", out_valid); end
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL bp_release_busy: got %b required 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] r;
        int seen;
        @(negedge clk);
        in_state = V_IN; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b required 0", out_valid); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
        tests++; if (out_state !== '0)   begin fails++; $display("FAIL mid_rst_state: got %h required 0", out_state); end
        tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL mid_rst_ready: got %b required 0", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL mid_rst_no_output: %0d valid cycles required 0", seen); end
        run_one(V_IN, 1'b0, "post_rst", r);
        tests++;
        if (r !== V_OUT) begin fails++; $display("FAIL post_rst_vector: got %h required %h", r, V_OUT); end
    endtask

    task automatic test_param_sweep();
        int t, l2, l4, l8;
        logic [127:0] r2, r4;
        logic [255:0] r8;
        l2 = 0; l4 = 0; l8 = 0; r2 = '0; r4 = '0; r8 = '0;
        @(negedge clk);
        s4 = V_IN; s8 = {V_IN, V_IN}; sinv = 1'b0; sro = 1'b1; sv = 1'b1;
        t = 0;
        while (!(rdy2 && rdy4 && rdy8) && t < 20) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        sv = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ov2 && l2 == 0) begin l2 = k; r2 = os2; end
            if (ov4 && l4 == 0) begin l4 = k; r4 = os4; end
            if (ov8 && l8 == 0) begin l8 = k; r8 = os8; end
        end
        tests++; if (l2 !== 2) begin fails++; $display("FAIL sweep42_latency: got %0d required 2", l2); end
        tests++; if (l4 !== 1) begin fails++; $display("FAIL sweep44_latency: got %0d required 1", l4); end
        tests++; if (l8 !== 4) begin fails++; $display("FAIL sweep82_latency: got %0d required 4", l8); end
        tests++; if (r2 !== V_OUT) begin fails++; $display("FAIL sweep42_data: got %h required %h", r2, V_OUT); end
        tests++; if (r4 !== V_OUT) begin fails++; $display("FAIL sweep44_data: got %h required %h", r4, V_OUT); end
        tests++;
        if (r8 !== {V_OUT, V_OUT}) begin fails++; $display("FAIL sweep82_data: got %h required %h", r8, {V_OUT, V_OUT}); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] cur, orig, e;
        logic         cinv, last_inv;
        int acc_n, out_n, cyc, last_acc, sp_bad;
        exp_q.delete();
        acc_n = 0; out_n = 0; cyc = 0; last_acc = 0; sp_bad = 0; last_inv = 1'b0;
        @(negedge clk);
        cur = rand128(); orig = cur; cinv = 1'b0;
        in_state = cur; in_inv = cinv; in_valid = 1'b1;
        while (out_n < 1000 && cyc < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_unexpected: output %h with empty scoreboard", out_state);
                end else begin
                    e = exp_q.pop_front();
                    if (out_state !== e) begin
                        fails++;
                        $display("FAIL b2b_data: txn %0d got %h required %h", out_n, out_state, e);
                    end
                end
                out_n++;
                // Every forward result is fed straight back in inverse mode.
                if (!last_inv) begin
                    cur = out_state; cinv = 1'b1;
                end else begin
                    cur = rand128(); orig = cur; cinv = 1'b0;
                end
                in_state = cur; in_inv = cinv;
                if (out_n >= 1000) in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                if (acc_n > 0 && (cyc - last_acc) < 6) sp_bad++;
                last_acc = cyc;
                e = model({128'h0, cur}, 1'b0, 4);
                exp_q.push_back(cinv ? orig : e);
                last_inv = cinv;
                acc_n++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        tests++; if (out_n !== 1000) begin fails++; $display("FAIL b2b_count: got %0d outputs required 1000", out_n); end
        tests++; if (sp_bad !== 0)   begin fails++; $display("FAIL b2b_spacing: %0d short gaps required 0", sp_bad); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_reset_mid_run();
        test_param_sweep();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
